// File: rtl/axi_read_arb_pkg.sv
// Shared CPU-side definitions for the AXI read arbiter: FSM encoding,
// burst type and requester index assignments.
package axi_read_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int unsigned ICACHE  = 0;
  localparam int unsigned DCACHE  = 1;
  localparam int unsigned UNCACHE = 2;

endpackage

// File: rtl/axi_read_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick
  import axi_read_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  // Scan from the farthest slot back toward ptr so the nearest requester is written last.
  always_comb begin
    onehot = '0;
    index  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned pos;
      pos = (32'(ptr) + N - 1 - k) % N;
      if (req[pos[IW-1:0]]) begin
        onehot                = '0;
        onehot[pos[IW-1:0]]   = 1'b1;
        index                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_read_arb.sv
// Single-outstanding AXI3 read arbiter: round-robin among N_MST requesters,
// forwards one AR, routes the R beats back to the granted requester.
module axi_read_arb
  import axi_read_arb_pkg::*;
#(
  parameter int unsigned N_MST = 3,
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MST-1:0]       m_arvalid,
  input  logic [N_MST*32-1:0]    m_araddr,
  input  logic [N_MST*LEN_W-1:0] m_arlen,
  input  logic [N_MST*3-1:0]     m_arsize,
  output logic [N_MST-1:0]       m_arready,
  output logic [N_MST-1:0]       m_rvalid,
  input  logic [N_MST-1:0]       m_rready,
  output logic [31:0]            m_rdata,
  output logic [1:0]             m_rresp,
  output logic                   m_rlast,
  output logic [3:0]             s_arid,
  output logic [31:0]            s_araddr,
  output logic [LEN_W-1:0]       s_arlen,
  output logic [2:0]             s_arsize,
  output logic [1:0]             s_arburst,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  input  logic [31:0]            s_rdata,
  input  logic [1:0]             s_rresp,
  input  logic                   s_rlast,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  output logic                   busy,
  output logic                   proto_err
);

  localparam int unsigned IW = (N_MST > 1) ? $clog2(N_MST) : 1;

  arb_state_t       r_state, w_next;
  logic [IW-1:0]    r_grant, r_rr_ptr, w_pick_idx, w_grant_inc;
  logic [N_MST-1:0] w_pick_onehot;
  logic [31:0]      r_addr, w_pick_addr;
  logic [LEN_W-1:0] r_len, w_pick_len, r_beat_cnt;
  logic [2:0]       r_size, w_pick_size;
  logic             w_r_hs;

  rr_pick #(
    .N  (N_MST),
    .IW (IW)
  ) u_rr_pick (
    .req    (m_arvalid),
    .ptr    (r_rr_ptr),
    .onehot (w_pick_onehot),
    .index  (w_pick_idx)
  );

  always_comb begin
    w_pick_addr = '0;
    w_pick_len  = '0;
    w_pick_size = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (w_pick_onehot[i]) begin
        w_pick_addr = m_araddr[i*32 +: 32];
        w_pick_len  = m_arlen[i*LEN_W +: LEN_W];
        w_pick_size = m_arsize[i*3 +: 3];
      end
    end
  end

  assign w_grant_inc = (r_grant == IW'(N_MST - 1)) ? '0 : r_grant + 1'b1;
  // Uses m_rready directly rather than s_rready to keep the handshake free of output feedback.
  assign w_r_hs      = (r_state == DATA) && s_rvalid && m_rready[r_grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (|m_arvalid) begin
          r_grant <= w_pick_idx;
          r_addr  <= w_pick_addr;
          r_len   <= w_pick_len;
          r_size  <= w_pick_size;
        end
        ADDR: if (s_arready) r_beat_cnt <= '0;
        DATA: if (w_r_hs) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          if (s_rlast) r_rr_ptr <= w_grant_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    s_arvalid = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    proto_err = 1'b0;
    case (r_state)
      IDLE: if (|m_arvalid) w_next = ADDR;
      ADDR: begin
        s_arvalid          = 1'b1;
        m_arready[r_grant] = s_arready;
        if (s_arready) w_next = DATA;
      end
      DATA: begin
        m_rvalid[r_grant] = s_rvalid;
        s_rready          = m_rready[r_grant];
        if (w_r_hs) begin
          proto_err = s_rlast != (r_beat_cnt == r_len);
          if (s_rlast) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign s_arid    = 4'(r_grant);
  assign s_araddr  = r_addr;
  assign s_arlen   = r_len;
  assign s_arsize  = r_size;
  assign s_arburst = AXI_BURST_INCR;
  assign busy      = (r_state != IDLE);
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

endmodule

// File: tb/tb_axi_read_arb.sv
// Directed bench for axi_read_arb: inputs change on the falling edge, outputs
// are compared 1 ns later, state advances on the rising edge.
module tb_axi_read_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [95:0] m_araddr;
  logic [11:0] m_arlen;
  logic [8:0]  m_arsize;
  logic [31:0] m_rdata, s_araddr, s_rdata;
  logic [1:0]  m_rresp, s_arburst, s_rresp;
  logic        m_rlast, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [3:0]  s_arid, s_arlen;
  logic [2:0]  s_arsize;
  logic        busy, proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  axi_read_arb #(.N_MST(3), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_rready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] l);
    m_araddr[i*32 +: 32] = a;
    m_arlen[i*4 +: 4]    = l;
    m_arsize[i*3 +: 3]   = 3'd2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_arvalid = 3'b111; s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 3'b111;
    @(negedge clk);
    n_tests++;
    if ({s_arvalid, s_rready, busy, proto_err, m_arready, m_rvalid} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {s_arvalid, s_rready, busy, proto_err, m_arready, m_rvalid});
    end
    @(negedge clk);
    n_tests++;
    if ({s_arvalid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hold: got %b expected 00", {s_arvalid, busy});
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 32'h1FC0_0040, 4'd7);
    m_arvalid = 3'b010;
    #1;
    n_tests++;
    if ({s_arvalid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_cycle_t: got %b expected 00", {s_arvalid, busy});
    end
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    n_tests++;
    if ({s_arvalid, s_arid, s_arlen, s_araddr, s_arburst, m_arready} !== {1'b1, 4'd1, 4'd7, 32'h1FC0_0040, 2'b01, 3'b010}) begin
      n_fail++;
      $display("FAIL single_ar: got v=%b id=%0d len=%0d addr=%h burst=%b ar=%b expected 1/1/7/1fc00040/01/010",
               s_arvalid, s_arid, s_arlen, s_araddr, s_arburst, m_arready);
    end
    @(negedge clk);
    m_arvalid = '0; s_arready = 1'b0; m_rready = 3'b111;
    for (int b = 0; b < 8; b++) begin
      s_rvalid = 1'b1; s_rdata = 32'hA000_0000 + b; s_rlast = (b == 7);
      #1;
      n_tests++;
      if ({m_rvalid, s_rready, proto_err, busy, m_rdata} !== {3'b010, 1'b1, 1'b0, 1'b1, 32'hA000_0000 + b}) begin
        n_fail++;
        $display("FAIL single_beat%0d: got rv=%b rr=%b pe=%b busy=%b d=%h expected 010/1/0/1/%h",
                 b, m_rvalid, s_rready, proto_err, busy, m_rdata, 32'hA000_0000 + b);
      end
      @(negedge clk);
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_tests++;
    if ({busy, m_rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL single_done: got busy=%b rv=%b expected 0/000", busy, m_rvalid);
    end
  endtask

  task automatic test_rr_order();
    int exp;
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 3; i++) set_req(i, 32'h100 * (i + 1), 4'd0);
    m_arvalid = 3'b111; s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 3'b111;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = k % 3;
      @(negedge clk);
      #1;
      n_tests++;
      if ({s_arvalid, s_arid, s_araddr, s_rready, m_rvalid} !== {1'b1, 4'(exp), 32'h100 * (exp + 1), 1'b0, 3'b000}) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got v=%b id=%0d addr=%h rr=%b rv=%b expected 1/%0d/%h/0/000",
                 k, s_arvalid, s_arid, s_araddr, s_rready, m_rvalid, exp, 32'h100 * (exp + 1));
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (m_rvalid !== (3'b001 << exp)) begin
        n_fail++; $display("FAIL rr_route%0d: got %b expected %b", k, m_rvalid, 3'b001 << exp);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_arready_stall();
    int pulses = 0;
    do_reset();
    set_req(0, 32'h8000_1000, 4'd1);
    m_arvalid = 3'b001;
    @(negedge clk);
    m_arvalid = '0;
    set_req(0, 32'hDEAD_0000, 4'd5);
    for (int c = 0; c < 5; c++) begin
      #1;
      pulses += int'(m_arready[0]);
      n_tests++;
      if ({s_arvalid, s_araddr, s_arlen} !== {1'b1, 32'h8000_1000, 4'd1}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b addr=%h len=%0d expected 1/80001000/1", c, s_arvalid, s_araddr, s_arlen);
      end
      @(negedge clk);
    end
    s_arready = 1'b1;
    #1;
    pulses += int'(m_arready[0]);
    @(negedge clk);
    s_arready = 1'b0;
    #1;
    pulses += int'(m_arready[0]);
    n_tests++;
    if ({s_arvalid, pulses} !== {1'b0, 32'd1}) begin
      n_fail++; $display("FAIL stall_pulse: got arvalid=%b pulses=%0d expected 0/1", s_arvalid, pulses);
    end
    m_rready = 3'b001;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1; s_rlast = (b == 1);
      #1;
      n_tests++;
      if ({m_rvalid, proto_err} !== {3'b001, 1'b0}) begin
        n_fail++; $display("FAIL stall_beat%0d: got rv=%b pe=%b expected 001/0", b, m_rvalid, proto_err);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_proto_err();
    do_reset();
    set_req(2, 32'h0000_2000, 4'd3);
    m_arvalid = 3'b100;
    @(negedge clk);
    m_arvalid = '0; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_rready = 3'b100; s_rvalid = 1'b1; s_rlast = 1'b0;
    #1;
    n_tests++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_beat0: got %b expected 0", proto_err); end
    @(negedge clk);
    s_rlast = 1'b1;
    #1;
    n_tests++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_early_last: got %b expected 1", proto_err); end
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_tests++;
    if ({proto_err, busy} !== 2'b00) begin
      n_fail++; $display("FAIL perr_idle: got pe=%b busy=%b expected 0/0", proto_err, busy);
    end
    set_req(2, 32'h0000_3000, 4'd0);
    m_arvalid = 3'b100;
    @(negedge clk);
    m_arvalid = '0; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0;
    #1;
    n_tests++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_missing_last: got %b expected 1", proto_err); end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_tests++;
    if ({busy, proto_err} !== 2'b10) begin
      n_fail++; $display("FAIL perr_stays_data: got busy=%b pe=%b expected 1/0", busy, proto_err);
    end
    s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    n_tests++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_late_last: got %b expected 1", proto_err); end
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL perr_end: got busy=%b expected 0", busy); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 32'h0000_4000, 4'd3);
    m_arvalid = 3'b001;
    @(negedge clk);
    m_arvalid = '0; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_rready = 3'b001; s_rvalid = 1'b1; s_rlast = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (m_rvalid !== 3'b001) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 001", m_rvalid); end
    #1;
    rst = 1'b1;
    s_arready = 1'b1;
    #1;
    n_tests++;
    if ({s_arvalid, s_rready, busy, proto_err, m_arready, m_rvalid} !== 10'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 0", {s_arvalid, s_rready, busy, proto_err, m_arready, m_rvalid});
    end
    clear_inputs();
    set_req(2, 32'h0000_5000, 4'd0);
    m_arvalid = 3'b100;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if ({s_arvalid, s_arid, s_araddr} !== {1'b1, 4'd2, 32'h0000_5000}) begin
      n_fail++; $display("FAIL rstmid_regrant: got v=%b id=%0d addr=%h expected 1/2/00005000", s_arvalid, s_arid, s_araddr);
    end
    m_arvalid = '0; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_rready = 3'b100; s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    n_tests++;
    if ({m_rvalid, proto_err} !== {3'b100, 1'b0}) begin
      n_fail++; $display("FAIL rstmid_beat: got rv=%b pe=%b expected 100/0", m_rvalid, proto_err);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_end: got busy=%b expected 0", busy); end
  endtask

  task automatic test_rready_backpressure();
    do_reset();
    set_req(1, 32'h0000_6000, 4'd1);
    m_arvalid = 3'b010;
    @(negedge clk);
    m_arvalid = '0; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_rready = 3'b101; s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({s_rready, m_rvalid} !== {1'b0, 3'b010}) begin
        n_fail++; $display("FAIL bp_stall%0d: got rr=%b rv=%b expected 0/010", c, s_rready, m_rvalid);
      end
      @(negedge clk);
    end
    m_rready = 3'b010;
    #1;
    n_tests++;
    if ({s_rready, proto_err, m_rdata} !== {1'b1, 1'b0, 32'h11}) begin
      n_fail++; $display("FAIL bp_beat0: got rr=%b pe=%b d=%h expected 1/0/11", s_rready, proto_err, m_rdata);
    end
    @(negedge clk);
    s_rdata = 32'h22; s_rlast = 1'b1;
    #1;
    n_tests++;
    if ({s_rready, proto_err} !== 2'b10) begin
      n_fail++; $display("FAIL bp_last: got rr=%b pe=%b expected 1/0", s_rready, proto_err);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_end: got busy=%b expected 0", busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_rr_order();
    test_arready_stall();
    test_proto_err();
    test_reset_mid_burst();
    test_rready_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arb.md
AXI_READ_ARB -- requirements
Module: axi_read_arb

Interface
REQ-001 Parameter N_MST, default 3, number of read requesters; index 0 is ICache refill, 1 is DCache refill, 2 is uncached load.
REQ-002 Parameter LEN_W, default 4, AXI3 burst-length width.
REQ-003 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port m_arvalid  in  N_MST  per-requester read-address valid.
REQ-006 Port m_araddr  in  N_MST x 32  per-requester physical address.
REQ-007 Port m_arlen, m_arsize  in  N_MST x LEN_W, N_MST x 3  per-requester burst length-1 and size.
REQ-008 Port m_arready  out  N_MST  per-requester address accept.
REQ-009 Port m_rvalid  out  N_MST  per-requester read-data valid.
REQ-010 Port m_rready  in  N_MST  per-requester read-data ready.
REQ-011 Port m_rdata, m_rresp, m_rlast  out  32, 2, 1  read data broadcast to all requesters.
REQ-012 Port s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid  out  4, 32, LEN_W, 3, 2, 1  downstream AR channel.
REQ-013 Port s_arready  in  1  downstream address accept.
REQ-014 Port s_rdata, s_rresp, s_rlast, s_rvalid  in  32, 2, 1, 1  downstream R channel.
REQ-015 Port s_rready  out  1  downstream data ready.
REQ-016 Port busy  out  1  high in any state except IDLE.
REQ-017 Port proto_err  out  1  one-cycle pulse on burst-length mismatch.

Function
REQ-018 FSM states IDLE, ADDR and DATA; exactly one read transaction outstanding at a time.
REQ-019 IDLE: if any m_arvalid is high, pick the winner by round-robin starting at rr_ptr, latch grant, address, length and size, and go to ADDR; otherwise stay in IDLE.
REQ-020 ADDR: drive s_arvalid=1 with the latched fields, s_arid={0,grant}, s_arburst=2'b01 (INCR); m_arready[grant]=s_arready, all other m_arready=0.
REQ-021 ADDR to DATA on s_arvalid&&s_arready; clear beat_cnt.
REQ-022 Latency: m_arvalid high in cycle t in IDLE gives s_arvalid high in cycle t+1.
REQ-023 DATA: m_rvalid[grant]=s_rvalid, other m_rvalid=0, s_rready=m_rready[grant]; each handshake increments beat_cnt.
REQ-024 DATA to IDLE on s_rvalid&&s_rready&&s_rlast; rr_ptr=(grant+1) mod N_MST; at least one IDLE cycle between transactions.
REQ-025 proto_err pulses when s_rlast arrives at beat_cnt!=latched arlen, or when beat_cnt==arlen is accepted without s_rlast; the FSM is unaffected.
REQ-026 s_rready=0 and every m_rvalid=0 outside DATA; stray s_rvalid there is ignored.
REQ-027 A requester dropping m_arvalid in ADDR has no effect; the latched request completes.
REQ-028 s_arvalid is held, with stable fields, until s_arready.

Reset
REQ-029 On rst (at any time, including mid-burst): state=IDLE, rr_ptr=0, grant=0, beat_cnt=0; s_arvalid, s_rready, busy, proto_err, m_arready and m_rvalid all 0 immediately.

Structure
REQ-030 arb_state_t, AXI_BURST_INCR and the requester index constants (ICACHE, DCACHE, UNCACHE) SHALL live in the shared CPU package.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs onehot and index).

Verification
REQ-032 Only req 1, addr 0x1FC0_0040, len 7 -> s_arvalid at t+1 with arid 1 and arlen 7; 8 beats routed only to m_rvalid[1]; busy falls after rlast.
REQ-033 All three requesting continuously from reset -> grant order 0,1,2,0.
REQ-034 s_arready held low 5 cycles -> s_arvalid and araddr stable throughout, m_arready[grant] pulses once.
REQ-035 len 3 with s_rlast on the 2nd beat -> proto_err is a single-cycle pulse and the FSM returns to IDLE.
REQ-036 rst asserted during beat 2 of 4 -> all outputs 0 asynchronously; after release a new request from 2 is granted normally.
REQ-037 m_rready[grant] low for 3 cycles in DATA -> s_rready low for those cycles and no beat is lost or counted.
